sram_port_arbiter: RTL

//   Shares the single-port synchronous SRAM between the fetch requester (IF) and the load/store requester (EX lsu).
//   One access is granted per cycle, and the read response is routed to its owner one cycle later.

---
 rtl/sram_port_arbiter_if.sv | 51 +++++
 rtl/sram_port_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the fetch, load/store and SRAM-side signals around the SRAM port arbiter.
// The arbiter uses the slave modport; the surrounding requesters and memory use master.
interface sram_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Fetch side
  logic              i_req;
  logic [AW-1:0]     i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DW-1:0]     i_rdata;
  logic              i_flush;
  // Load/store side
  logic              d_req;
  logic [DW/8-1:0]   d_we;
  logic [AW-1:0]     d_addr;
  logic [DW-1:0]     d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DW-1:0]     d_rdata;
  // Pipeline stall requests
  logic              stallreq_if;
  logic              stallreq_ls;
  // SRAM side
  logic              sram_en;
  logic [DW/8-1:0]   sram_we;
  logic [AW-1:0]     sram_addr;
  logic [DW-1:0]     sram_wdata;
  logic [DW-1:0]     sram_rdata;

  modport slave (
    input  i_req, i_addr, i_flush,
    input  d_req, d_we, d_addr, d_wdata,
    input  sram_rdata,
    output i_gnt, i_rvalid, i_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output stallreq_if, stallreq_ls,
    output sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output i_req, i_addr, i_flush,
    output d_req, d_we, d_addr, d_wdata,
    output sram_rdata,
    input  i_gnt, i_rvalid, i_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  stallreq_if, stallreq_ls,
    input  sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and load/store,
// one access per cycle, with read data steered to its owner the following cycle.
module sram_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_port_arbiter_if.slave   bus
);

  localparam int         BW         = DW / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_INST = 2'd1;
  localparam logic [1:0] OWN_DATA = 2'd2;

  logic [1:0] owner_q, owner_d;
  logic [3:0] starve_q, starve_d;

  logic force_i;
  logic i_gnt;
  logic d_gnt;
  logic d_is_load;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= STARVE_LIM) ? STARVE_LIM : v + 4'd1;
  endfunction

  // Load/store wins by default; fetch takes the port once it has been refused STARVE_MAX times.
  always_comb begin
    force_i   = (starve_q == STARVE_LIM);
    d_gnt     = rst_n & bus.d_req & ~(force_i & bus.i_req);
    i_gnt     = rst_n & bus.i_req & ~d_gnt;
    d_is_load = (bus.d_we == '0);
  end

  assign bus.i_gnt       = i_gnt;
  assign bus.d_gnt       = d_gnt;
  assign bus.stallreq_if = bus.i_req & ~i_gnt;
  assign bus.stallreq_ls = bus.d_req & ~d_gnt;

  always_comb begin
    bus.sram_en    = i_gnt | d_gnt;
    bus.sram_we    = '0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (d_gnt) begin
      bus.sram_we    = bus.d_we;
      bus.sram_addr  = bus.d_addr;
      bus.sram_wdata = bus.d_wdata;
    end else if (i_gnt) begin
      bus.sram_addr  = bus.i_addr;
    end
  end

  // Stores complete on grant, and a fetch granted alongside a flush is dropped.
  always_comb begin
    owner_d = OWN_NONE;
    if (i_gnt && !bus.i_flush) begin
      owner_d = OWN_INST;
    end else if (d_gnt && d_is_load) begin
      owner_d = OWN_DATA;
    end
  end

  always_comb begin
    starve_d = 4'd0;
    if (bus.i_req && !i_gnt) begin
      starve_d = sat_inc(starve_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= OWN_NONE;
      starve_q <= 4'd0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  // Read data is shared; the rvalids decide who may consume it.
  assign bus.i_rvalid = (owner_q == OWN_INST) & ~bus.i_flush;
  assign bus.d_rvalid = (owner_q == OWN_DATA);
  assign bus.i_rdata  = bus.sram_rdata;
  assign bus.d_rdata  = bus.sram_rdata;

  logic [BW-1:0] unused_bw;
  assign unused_bw = '0;

endmodule
